// File: rtl/cevero_dvfs_sequencer.sv
// cevero_dvfs_sequencer: moves the core between DVFS operating points in a safe order.
// On scale-up the voltage ramps one code at a time before the frequency is raised.
// On scale-down the frequency drops before the voltage ramps down.
// Optional macro CEVERO_DVFS_RANGE_CHECK_EN refuses requests with a zero voltage code or zero frequency.
module cevero_dvfs_sequencer #(
  parameter int VOLT_W        = 3,
  parameter int FREQ_W        = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_CYCLES   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [VOLT_W-1:0] def_voltage_i,
  input  logic [FREQ_W-1:0] def_freq_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [VOLT_W-1:0] req_voltage_i,
  input  logic [FREQ_W-1:0] req_freq_i,
  output logic [VOLT_W-1:0] set_voltage_o,
  output logic [FREQ_W-1:0] set_freq_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              reject_o
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_V_UP, ST_F_UP, ST_F_DN, ST_V_DN, ST_DONE
  } state_t;

  state_t            r_state;
  logic [VOLT_W-1:0] r_volt;
  logic [FREQ_W-1:0] r_freq;
  logic [CNT_W-1:0]  r_cnt;
  logic [VOLT_W-1:0] r_tv;
  logic [FREQ_W-1:0] r_tf;

  state_t            w_state_next;
  logic [VOLT_W-1:0] w_volt_next;
  logic [FREQ_W-1:0] w_freq_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [VOLT_W-1:0] w_tv_next;
  logic [FREQ_W-1:0] w_tf_next;
  logic              w_accept;
  logic              w_bad;

  assign w_accept    = req_valid_i && (r_state == ST_IDLE);
  assign req_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE);
  assign set_voltage_o = r_volt;
  assign set_freq_o    = r_freq;

`ifdef CEVERO_DVFS_RANGE_CHECK_EN
  logic r_reject;

  assign w_bad    = (req_voltage_i == '0) || (req_freq_i == '0);
  assign reject_o = r_reject;

  // One-cycle refusal pulse following a handshake that carried an out-of-range target
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_reject <= 1'b0;
    else         r_reject <= w_accept && w_bad;
  end
`else
  assign w_bad    = 1'b0;
  assign reject_o = 1'b0;
`endif

  // State, setpoint, counter and latched-target registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_INIT;
      r_volt  <= '0;
      r_freq  <= '0;
      r_cnt   <= '0;
      r_tv    <= '0;
      r_tf    <= '0;
    end else begin
      r_state <= w_state_next;
      r_volt  <= w_volt_next;
      r_freq  <= w_freq_next;
      r_cnt   <= w_cnt_next;
      r_tv    <= w_tv_next;
      r_tf    <= w_tf_next;
    end
  end

  // Sequencing rules: voltage steps one code per settle window, frequency written once
  always_comb begin
    w_state_next = r_state;
    w_volt_next  = r_volt;
    w_freq_next  = r_freq;
    w_cnt_next   = r_cnt;
    w_tv_next    = r_tv;
    w_tf_next    = r_tf;
    case (r_state)
      ST_INIT: begin
        w_volt_next  = def_voltage_i;
        w_freq_next  = def_freq_i;
        w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_accept && !w_bad) begin
          w_tv_next = req_voltage_i;
          w_tf_next = req_freq_i;
          if (req_voltage_i > r_volt) begin
            // Scale-up: first voltage step happens on the accept edge
            w_state_next = ST_V_UP;
            w_volt_next  = r_volt + 1'b1;
            w_cnt_next   = SETTLE_LD;
          end else if ((req_voltage_i < r_volt) || (req_freq_i != r_freq)) begin
            // Scale-down or frequency-only change: frequency moves first
            w_state_next = ST_F_DN;
            w_freq_next  = req_freq_i;
            w_cnt_next   = LOCK_LD;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_V_UP: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (r_volt != r_tv) begin
          w_volt_next = r_volt + 1'b1;
          w_cnt_next  = SETTLE_LD;
        end else begin
          w_state_next = ST_F_UP;
          w_freq_next  = r_tf;
          w_cnt_next   = LOCK_LD;
        end
      end
      ST_F_UP: begin
        if (r_cnt != '0) w_cnt_next = r_cnt - 1'b1;
        else             w_state_next = ST_DONE;
      end
      ST_F_DN: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (r_volt == r_tv) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_V_DN;
          w_volt_next  = r_volt - 1'b1;
          w_cnt_next   = SETTLE_LD;
        end
      end
      ST_V_DN: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (r_volt != r_tv) begin
          w_volt_next = r_volt - 1'b1;
          w_cnt_next  = SETTLE_LD;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_INIT;
    endcase
  end

endmodule

// File: doc/cevero_dvfs_sequencer.md
Name: cevero_dvfs_sequencer

Overview:
Controller that moves the CEVERO core between DVFS operating points (voltage code, frequency word) safely. It accepts a target point over a valid/ready handshake and drives the voltage and frequency setpoints in the safe order. Voltage rises before frequency on scale-up. Frequency drops before voltage on scale-down. Voltage moves one code per step, with settle and lock waits between actions. Sits between the error-driven DVFS policy logic (requester) and the regulator/PLL configuration registers.

Parameters:
VOLT_W, 3, voltage code width
FREQ_W, 32, frequency word width
SETTLE_CYCLES, 16, cycles each voltage code is held before the next action (legal range 1..1023)
LOCK_CYCLES, 8, cycles the new frequency is held before the next action (legal range 1..1023)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
def_voltage_i  in  VOLT_W  default voltage code loaded after reset
def_freq_i  in  FREQ_W  default frequency loaded after reset
req_valid_i  in  1  target operating point valid
req_ready_o  out  1  sequencer can accept a request
req_voltage_i  in  VOLT_W  target voltage code
req_freq_i  in  FREQ_W  target frequency
set_voltage_o  out  VOLT_W  voltage setpoint to regulator
set_freq_o  out  FREQ_W  frequency setpoint to PLL/divider
busy_o  out  1  transition in progress (state != IDLE)
done_o  out  1  one-cycle pulse when a request completes
reject_o  out  1  one-cycle pulse when a request is refused (see Optional Feature)

Behaviour:
- Reset (async): state=INIT; set_voltage_o=0, set_freq_o=0, done_o=0, reject_o=0, req_ready_o=0, busy_o=1. Counter=0. Latched targets=0.
- INIT: first edge after rst_ni deasserts loads set_voltage_o<=def_voltage_i and set_freq_o<=def_freq_i, then goes to IDLE. No done_o pulse.
- IDLE: req_ready_o=1, busy_o=0. A request is accepted on an edge where req_valid_i & req_ready_o. Targets tV/tF are latched at that edge.
- Accept-edge dispatch, comparing tV against the current set_voltage_o (unsigned):
  - tV > cur: go to V_UP. Same edge: set_voltage_o<=cur+1, cnt<=SETTLE_CYCLES-1.
  - tV < cur: go to F_DN. Same edge: set_freq_o<=tF, cnt<=LOCK_CYCLES-1.
  - tV == cur and tF != cur freq: go to F_DN. Same actions as tV < cur; it exits straight to DONE.
  - tV == cur and tF == cur freq: go to DONE.
- V_UP, each edge:
  - If cnt!=0, cnt--.
  - Else if set_voltage_o!=tV, step +1 and reload SETTLE_CYCLES-1.
  - Else go to F_UP, with set_freq_o<=tF and cnt<=LOCK_CYCLES-1.
- F_UP, each edge: cnt-- until 0, then go to DONE.
- F_DN, each edge:
  - If cnt!=0, cnt--.
  - Else if set_voltage_o==tV, go to DONE.
  - Else go to V_DN with set_voltage_o-=1 and cnt<=SETTLE_CYCLES-1.
- V_DN, each edge:
  - If cnt!=0, cnt--.
  - Else if set_voltage_o!=tV, step -1 and reload.
  - Else go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. req_ready_o is low in DONE.
- Latency: accept edge to the edge entering DONE = |tV-cur|*SETTLE_CYCLES + LOCK_CYCLES edges when frequency or voltage changes. The frequency wait is always applied when voltage changes, even if tF equals the current frequency. A no-op request takes 1 edge.
- Voltage steps by exactly 1 code per step, with no wrap. Frequency changes in a single write.
- Requests are never queued or preempted. While busy, req_ready_o=0 and inputs are ignored. A request held across DONE is accepted only in IDLE.
- Counter width is 10 bits.
- Reset asserted mid-transition immediately returns all outputs to reset values. INIT then reloads defaults, not the old targets.

Optional Feature:
Macro CEVERO_DVFS_RANGE_CHECK_EN.
- With it: an accepted request with req_voltage_i==0 or req_freq_i==0 is refused. Handshake completes, reject_o pulses 1 cycle on the next cycle, setpoints are unchanged, no done_o, state stays IDLE.
- Without it: reject_o is tied 0 and such requests are sequenced normally (e.g., ramp voltage down to code 0).

Test Plan:
- Reset, defaults 5/150: after rst_ni rises, set_voltage_o=5 and set_freq_o=150 one edge later; req_ready_o=1; no done_o.
- SETTLE=4, LOCK=3, request 7/200 from 5/150 -> voltage 6 at accept, 7 at +4 edges, freq 200 at +8, DONE at +11, done_o one cycle, ready restored next cycle.
- Request 3/100 from 5/150 -> freq 100 at accept, voltage 4 at +3, 3 at +7, DONE at +11; voltage never below 3.
- Request 5/150 from 5/150 -> DONE next edge, outputs unchanged. Request 5/90 -> freq 90 at accept, DONE at +3.
- req_valid_i held high during a transition with a different target -> ignored until IDLE; then accepted. Async reset at the mid-ramp +5 edge -> outputs 0 immediately, defaults 5/150 after release.
- With CEVERO_DVFS_RANGE_CHECK_EN, request 0/150 -> reject_o pulse, setpoints stay 5/150, no done_o. Without the macro, the same request ramps voltage down to 0.
